free_list: RTL

FREE_LIST -- requirements
Module: free_list

---
 rtl/free_list_if.sv | 43 ++++
 rtl/free_list.sv | 125 ++++++++++++
 2 files changed

// File: rtl/free_list_if.sv
// Rename-side and retire-side signals of the physical register free list.
// dup_err exists only when FREE_LIST_DUP_CHECK_EN is defined.
interface free_list_if #(
  parameter int PREG_COUNT = 64
);
  localparam int IDX_W = $clog2(PREG_COUNT);
  localparam int PTR_W = IDX_W + 1;

  // alloc_req_* are level requests with zero-cycle grants: the granted
  // registers are valid in the same cycle, and they are consumed at the next
  // rising edge only when alloc_stall is low. rel_valid_* each mark one
  // release, which is taken at that edge or dropped (no backpressure).
  logic             alloc_req_0;
  logic             alloc_req_1;
  logic [IDX_W-1:0] alloc_preg_0;
  logic [IDX_W-1:0] alloc_preg_1;
  logic             alloc_stall;
  logic             rel_valid_0;
  logic [IDX_W-1:0] rel_preg_0;
  logic             rel_valid_1;
  logic [IDX_W-1:0] rel_preg_1;
  logic [PTR_W-1:0] free_count;
  logic             overflow_err;
`ifdef FREE_LIST_DUP_CHECK_EN
  logic             dup_err;
`endif

  modport master (
    output alloc_req_0, alloc_req_1, rel_valid_0, rel_preg_0, rel_valid_1, rel_preg_1,
    input  alloc_preg_0, alloc_preg_1, alloc_stall, free_count, overflow_err
`ifdef FREE_LIST_DUP_CHECK_EN
    , input dup_err
`endif
  );

  modport slave (
    input  alloc_req_0, alloc_req_1, rel_valid_0, rel_preg_0, rel_valid_1, rel_preg_1,
    output alloc_preg_0, alloc_preg_1, alloc_stall, free_count, overflow_err
`ifdef FREE_LIST_DUP_CHECK_EN
    , output dup_err
`endif
  );
endinterface

// File: rtl/free_list.sv
// Circular-FIFO free list of physical registers: two grant ports, two release ports.
// Optional FREE_LIST_DUP_CHECK_EN adds an in-list bitmap that rejects duplicate releases.
module free_list #(
  parameter int PREG_COUNT = 64,
  parameter int ARCH_COUNT = 32
) (
  input  logic        clk,
  input  logic        rst,
  free_list_if.slave  fl
);
  localparam int IDX_W = $clog2(PREG_COUNT);
  localparam int PTR_W = IDX_W + 1;

  logic [IDX_W-1:0] mem_q [PREG_COUNT];
  logic [IDX_W-1:0] mem_d [PREG_COUNT];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] free_count_q, free_count_d;
  logic             overflow_err_q, overflow_err_d;

  logic [1:0]       req_cnt;
  logic [1:0]       pop_cnt;
  logic             stall;
  logic [IDX_W-1:0] head_idx, head_idx_1, tail_idx, tail_idx_1;
  logic [PTR_W-1:0] room;
  logic             dup0, dup1;
  logic             cand0, cand1, acc0, acc1;
  logic             full_drop;

  assign head_idx   = head_q[IDX_W-1:0];
  assign head_idx_1 = head_idx + 1'b1;
  assign tail_idx   = tail_q[IDX_W-1:0];
  assign tail_idx_1 = tail_idx + 1'b1;

  // All-or-nothing grant: a request larger than the occupancy pops nothing.
  always_comb begin
    req_cnt = 2'd0;
    if (fl.alloc_req_0) req_cnt = fl.alloc_req_1 ? 2'd2 : 2'd1;
  end

  assign stall   = {{(PTR_W-2){1'b0}}, req_cnt} > free_count_q;
  assign pop_cnt = stall ? 2'd0 : req_cnt;

  assign fl.alloc_preg_0 = mem_q[head_idx];
  assign fl.alloc_preg_1 = mem_q[head_idx_1];
  assign fl.alloc_stall  = stall;
  assign fl.free_count   = free_count_q;
  assign fl.overflow_err = overflow_err_q;

`ifdef FREE_LIST_DUP_CHECK_EN
  logic [PREG_COUNT-1:0] in_list_q, in_list_d;
  logic                  dup_err_q, dup_err_d;
  logic                  dup_hit;

  assign dup0 = in_list_q[fl.rel_preg_0];
  assign dup1 = in_list_q[fl.rel_preg_1] ||
                (fl.rel_valid_0 && (fl.rel_preg_1 == fl.rel_preg_0));
  assign dup_hit = (fl.rel_valid_0 && (fl.rel_preg_0 != '0) && dup0) ||
                   (fl.rel_valid_1 && (fl.rel_preg_1 != '0) && dup1);
  assign fl.dup_err = dup_err_q;

  // Pops clear first so a release can only mark a register that is truly out.
  always_comb begin
    in_list_d = in_list_q;
    if (pop_cnt != 2'd0) in_list_d[mem_q[head_idx]] = 1'b0;
    if (pop_cnt == 2'd2) in_list_d[mem_q[head_idx_1]] = 1'b0;
    if (acc0) in_list_d[fl.rel_preg_0] = 1'b1;
    if (acc1) in_list_d[fl.rel_preg_1] = 1'b1;
    dup_err_d = dup_err_q | dup_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PREG_COUNT; i++) in_list_q[i] <= (i >= ARCH_COUNT);
      dup_err_q <= 1'b0;
    end else begin
      in_list_q <= in_list_d;
      dup_err_q <= dup_err_d;
    end
  end
`else
  assign dup0 = 1'b0;
  assign dup1 = 1'b0;
`endif

  // Fullness is judged on pre-pop occupancy, so a same-cycle pop never frees
  // room for a release.
  always_comb begin
    room      = PTR_W'(PREG_COUNT) - free_count_q;
    cand0     = fl.rel_valid_0 && (fl.rel_preg_0 != '0) && !dup0;
    cand1     = fl.rel_valid_1 && (fl.rel_preg_1 != '0) && !dup1;
    acc0      = cand0 && (room != '0);
    acc1      = cand1 && (room > {{(PTR_W-1){1'b0}}, acc0});
    full_drop = (cand0 && !acc0) || (cand1 && !acc1);
  end

  always_comb begin
    mem_d = mem_q;
    if (acc0) mem_d[tail_idx] = fl.rel_preg_0;
    if (acc1) mem_d[acc0 ? tail_idx_1 : tail_idx] = fl.rel_preg_1;
    head_d         = head_q + {{(PTR_W-2){1'b0}}, pop_cnt};
    tail_d         = tail_q + {{(PTR_W-1){1'b0}}, acc0} + {{(PTR_W-1){1'b0}}, acc1};
    free_count_d   = free_count_q + {{(PTR_W-1){1'b0}}, acc0} +
                     {{(PTR_W-1){1'b0}}, acc1} - {{(PTR_W-2){1'b0}}, pop_cnt};
    overflow_err_d = overflow_err_q | full_drop;
  end

  // Registers p(ARCH_COUNT).. are free at reset; lower ones hold architectural state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PREG_COUNT; i++)
        mem_q[i] <= (i < PREG_COUNT - ARCH_COUNT) ? IDX_W'(ARCH_COUNT + i) : '0;
      head_q         <= '0;
      tail_q         <= PTR_W'(PREG_COUNT - ARCH_COUNT);
      free_count_q   <= PTR_W'(PREG_COUNT - ARCH_COUNT);
      overflow_err_q <= 1'b0;
    end else begin
      mem_q          <= mem_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      free_count_q   <= free_count_d;
      overflow_err_q <= overflow_err_d;
    end
  end
endmodule
